// File: rtl/spmdv_pkg.sv
// spmdv_pkg: shared constants and phase encoding for the SpMDV load path.
//   SPMDV_BANK_DEPTH  words per weight bank (also vector SRAM depth)
//   SPMDV_NUM_BANKS   weight banks per array
//   SPMDV_BIAS_DEPTH  bias entries
//   SPMDV_W_TOTAL     weight entries per array (banks * depth)
//   spmdv_phase_t     load sequencer phase, codes visible on the phase output
package spmdv_pkg;

  localparam int unsigned SPMDV_BANK_DEPTH = 4096;
  localparam int unsigned SPMDV_NUM_BANKS  = 3;
  localparam int unsigned SPMDV_BIAS_DEPTH = 256;
  localparam int unsigned SPMDV_W_TOTAL    = SPMDV_BANK_DEPTH * SPMDV_NUM_BANKS;

  localparam int unsigned SPMDV_CNT_W = 14;

  typedef enum logic [2:0] {
    PhIdle = 3'd0,
    PhWval = 3'd1,
    PhWpos = 3'd2,
    PhBias = 3'd3,
    PhVec  = 3'd4,
    PhDone = 3'd5
  } spmdv_phase_t;

  // Phases fed by the ld_w_request / w_input_valid handshake.
  function automatic logic spmdv_is_w_phase(input spmdv_phase_t ph);
    return (ph == PhWval) || (ph == PhWpos) || (ph == PhBias);
  endfunction

endpackage

// File: rtl/spmdv_bank_decode.sv
// spmdv_bank_decode: turns a weight bank index plus enable into an active-low,
// one-hot-low chip-enable vector. Out-of-range index or enable low -> all ones.
//   i_bank  bank index
//   i_en    write enable for this array
//   o_cen   per-bank CEN, active-low
module spmdv_bank_decode
  import spmdv_pkg::*;
(
  input  logic [1:0]                 i_bank,
  input  logic                       i_en,
  output logic [SPMDV_NUM_BANKS-1:0] o_cen
);

  always_comb begin
    o_cen = '1;
    for (int unsigned b = 0; b < SPMDV_NUM_BANKS; b++) begin
      if (i_en && (i_bank == 2'(b))) begin
        o_cen[b] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/spmdv_load_sequencer.sv
// spmdv_load_sequencer: sequences the SpMDV initialisation load (weight values,
// weight positions, bias, input vectors) and drives the source handshakes and
// SRAM CEN/WEN/address pins. Once o_load_done is high the SRAMs belong to the
// compute engine.
//
// Optional feature: define SPMDV_LDSEQ_OVERRUN_CNT_EN to add o_overrun_cnt, a
// saturating count of cycles where a valid arrives while its request is low.
//
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_start_init              level; enables weight/bias requests, rise starts a load
//   i_w_input_valid           weight/bias item valid
//   i_raw_data_valid          vector item valid
//   o_ld_w_request            weight/bias request (registered)
//   o_raw_data_request        vector request (registered)
//   o_wv_cen, o_wp_cen        weight value / position bank CEN, active-low
//   o_w_wen, o_w_addr         weight bank WEN (active-low) and address
//   o_bias_cen/wen/addr       bias SRAM pins
//   o_vec_cen/wen/addr        vector SRAM pins
//   o_phase                   current phase code
//   o_overrun_cnt             (optional) ignored-valid counter
//   o_load_done               high in DONE
module spmdv_load_sequencer
  import spmdv_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start_init,
  input  logic                       i_w_input_valid,
  input  logic                       i_raw_data_valid,
  output logic                       o_ld_w_request,
  output logic                       o_raw_data_request,
  output logic [SPMDV_NUM_BANKS-1:0] o_wv_cen,
  output logic [SPMDV_NUM_BANKS-1:0] o_wp_cen,
  output logic                       o_w_wen,
  output logic [11:0]                o_w_addr,
  output logic                       o_bias_cen,
  output logic                       o_bias_wen,
  output logic [7:0]                 o_bias_addr,
  output logic                       o_vec_cen,
  output logic                       o_vec_wen,
  output logic [11:0]                o_vec_addr,
  output logic [2:0]                 o_phase,
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
  output logic [15:0]                o_overrun_cnt,
`endif
  output logic                       o_load_done
);

  localparam logic [SPMDV_CNT_W-1:0] CntWLast    = SPMDV_CNT_W'(SPMDV_W_TOTAL - 1);
  localparam logic [SPMDV_CNT_W-1:0] CntBiasLast = SPMDV_CNT_W'(SPMDV_BIAS_DEPTH - 1);
  localparam logic [SPMDV_CNT_W-1:0] CntVecLast  = SPMDV_CNT_W'(SPMDV_BANK_DEPTH - 1);

  spmdv_phase_t           r_state;
  spmdv_phase_t           w_state_d;
  logic [SPMDV_CNT_W-1:0] r_cnt;
  logic [SPMDV_CNT_W-1:0] w_cnt_d;
  logic                   r_start_prev;
  logic                   r_ld_w_req;
  logic                   r_raw_req;

  logic                   w_start_rise;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_enter_wval;
  logic                   w_wv_en;
  logic                   w_wp_en;
  logic                   w_ld_w_req_d;
  logic                   w_raw_req_d;

  assign w_start_rise = i_start_init & ~r_start_prev;

  // Accept and end-of-source detection for the current phase.
  always_comb begin
    w_accept = 1'b0;
    w_last   = 1'b0;
    unique case (r_state)
      PhWval, PhWpos: begin
        w_accept = i_w_input_valid & r_ld_w_req;
        w_last   = w_accept & (r_cnt == CntWLast);
      end
      PhBias: begin
        w_accept = i_w_input_valid & r_ld_w_req;
        w_last   = w_accept & (r_cnt == CntBiasLast);
      end
      PhVec: begin
        w_accept = i_raw_data_valid & r_raw_req;
        w_last   = w_accept & (r_cnt == CntVecLast);
      end
      default: begin
        w_accept = 1'b0;
        w_last   = 1'b0;
      end
    endcase
  end

  // FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= PhIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state. A start rise only matters in IDLE or DONE.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      PhIdle, PhDone: if (w_start_rise) w_state_d = PhWval;
      PhWval:         if (w_last)       w_state_d = PhWpos;
      PhWpos:         if (w_last)       w_state_d = PhBias;
      PhBias:         if (w_last)       w_state_d = PhVec;
      PhVec:          if (w_last)       w_state_d = PhDone;
      default:                          w_state_d = PhIdle;
    endcase
  end

  assign w_enter_wval = ((r_state == PhIdle) || (r_state == PhDone)) && (w_state_d == PhWval);

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_enter_wval || w_last) begin
      w_cnt_d = '0;
    end else if (w_accept) begin
      w_cnt_d = r_cnt + SPMDV_CNT_W'(1);
    end
  end

  // Requests are computed from the next state so they stay high across the
  // WVAL->WPOS->BIAS boundaries and drop on the edge of the final accept.
  assign w_ld_w_req_d = spmdv_is_w_phase(w_state_d) & i_start_init;
  assign w_raw_req_d  = (w_state_d == PhVec);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_start_prev <= 1'b0;
      r_ld_w_req   <= 1'b0;
      r_raw_req    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_start_prev <= i_start_init;
      r_ld_w_req   <= w_ld_w_req_d;
      r_raw_req    <= w_raw_req_d;
    end
  end

  // FSM: outputs. SRAM pins are combinational off the accept so the write
  // lands on the same edge that the accept is registered.
  assign w_wv_en = w_accept & (r_state == PhWval);
  assign w_wp_en = w_accept & (r_state == PhWpos);

  spmdv_bank_decode u_wv_decode (
    .i_bank (r_cnt[13:12]),
    .i_en   (w_wv_en),
    .o_cen  (o_wv_cen)
  );

  spmdv_bank_decode u_wp_decode (
    .i_bank (r_cnt[13:12]),
    .i_en   (w_wp_en),
    .o_cen  (o_wp_cen)
  );

  always_comb begin
    o_w_wen     = ~(w_wv_en | w_wp_en);
    o_w_addr    = (w_wv_en | w_wp_en) ? r_cnt[11:0] : 12'd0;
    o_bias_cen  = 1'b1;
    o_bias_wen  = 1'b1;
    o_bias_addr = 8'd0;
    o_vec_cen   = 1'b1;
    o_vec_wen   = 1'b1;
    o_vec_addr  = 12'd0;
    if (w_accept && (r_state == PhBias)) begin
      o_bias_cen  = 1'b0;
      o_bias_wen  = 1'b0;
      o_bias_addr = r_cnt[7:0];
    end
    if (w_accept && (r_state == PhVec)) begin
      o_vec_cen  = 1'b0;
      o_vec_wen  = 1'b0;
      o_vec_addr = r_cnt[11:0];
    end
  end

  assign o_ld_w_request     = r_ld_w_req;
  assign o_raw_data_request = r_raw_req;
  assign o_phase            = r_state;
  assign o_load_done        = (r_state == PhDone);

`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
  logic [15:0] r_overrun_cnt;
  logic        w_overrun;

  assign w_overrun = (i_w_input_valid & ~r_ld_w_req) | (i_raw_data_valid & ~r_raw_req);

  // Clearing on WVAL entry wins over a same-cycle overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun_cnt <= '0;
    end else if (w_enter_wval) begin
      r_overrun_cnt <= '0;
    end else if (w_overrun && (r_overrun_cnt != 16'hFFFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end

  assign o_overrun_cnt = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_spmdv_load_sequencer.sv
// Directed bench for spmdv_load_sequencer: full load, bank boundary,
// start_init drop/resume, ignored valids, and mid-load reset.
module tb_spmdv_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_init = 1'b0;
  logic        w_valid = 1'b0;
  logic        raw_valid = 1'b0;
  logic        ld_w_req, raw_req, w_wen, bias_cen, bias_wen, vec_cen, vec_wen, load_done;
  logic [2:0]  wv_cen, wp_cen, phase;
  logic [11:0] w_addr, vec_addr;
  logic [7:0]  bias_addr;
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
  logic [15:0] ovr;
`endif

  spmdv_load_sequencer u_dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start_init       (start_init),
    .i_w_input_valid    (w_valid),
    .i_raw_data_valid   (raw_valid),
    .o_ld_w_request     (ld_w_req),
    .o_raw_data_request (raw_req),
    .o_wv_cen           (wv_cen),
    .o_wp_cen           (wp_cen),
    .o_w_wen            (w_wen),
    .o_w_addr           (w_addr),
    .o_bias_cen         (bias_cen),
    .o_bias_wen         (bias_wen),
    .o_bias_addr        (bias_addr),
    .o_vec_cen          (vec_cen),
    .o_vec_wen          (vec_wen),
    .o_vec_addr         (vec_addr),
    .o_phase            (phase),
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
    .o_overrun_cnt      (ovr),
`endif
    .o_load_done        (load_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+2, outputs are sampled at posedge+2/+3.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    #1;
  endtask

  // Reset/idle view of all control pins and addresses.
  task automatic check_quiet(input string tag, input logic [2:0] exp_phase,
                             input logic exp_done);
    check_eq({tag, "_ctrl"},
             {15'd0, ld_w_req, raw_req, wv_cen, wp_cen, w_wen, bias_cen, bias_wen,
              vec_cen, vec_wen, load_done, phase},
             {15'd0, 1'b0, 1'b0, 3'b111, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              exp_done, exp_phase});
    check_eq({tag, "_addr"}, {w_addr, bias_addr, vec_addr}, 32'd0);
  endtask

  // Write monitor: counts SRAM writes at the negedge and checks each write
  // against the order the load must follow.
  int          n_wv [3];
  int          n_wp, n_bias, n_vec;
  int          wv_idx, wp_idx, bias_idx, vec_idx, mon_err;
  int          m_k, m_b;
  logic [2:0]  m_cen;

  initial begin
    for (int i = 0; i < 3; i++) n_wv[i] = 0;
    n_wp = 0; n_bias = 0; n_vec = 0;
    wv_idx = 0; wp_idx = 0; bias_idx = 0; vec_idx = 0; mon_err = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wv_cen != 3'b111 && wp_cen != 3'b111) mon_err++;
      if (wv_cen == 3'b111 && wp_cen == 3'b111 && w_wen !== 1'b1) mon_err++;
      if (wv_cen != 3'b111) begin
        m_k = wv_idx % 12288;
        m_b = m_k / 4096;
        m_cen = 3'b111;
        m_cen[m_b] = 1'b0;
        if (wv_cen !== m_cen || w_addr !== 12'(m_k % 4096) || w_wen !== 1'b0) mon_err++;
        else n_wv[m_b]++;
        wv_idx++;
      end
      if (wp_cen != 3'b111) begin
        m_k = wp_idx % 12288;
        m_b = m_k / 4096;
        m_cen = 3'b111;
        m_cen[m_b] = 1'b0;
        if (wp_cen !== m_cen || w_addr !== 12'(m_k % 4096) || w_wen !== 1'b0) mon_err++;
        else n_wp++;
        wp_idx++;
      end
      if (bias_cen !== bias_wen) mon_err++;
      if (!bias_cen) begin
        if (bias_addr !== 8'(bias_idx % 256)) mon_err++;
        else n_bias++;
        bias_idx++;
      end
      if (vec_cen !== vec_wen) mon_err++;
      if (!vec_cen) begin
        if (vec_addr !== 12'(vec_idx % 4096)) mon_err++;
        else n_vec++;
        vec_idx++;
      end
    end
  end

  function automatic int total_wr();
    return n_wv[0] + n_wv[1] + n_wv[2] + n_wp + n_bias + n_vec;
  endfunction

  int snap;

  initial begin
    // Reset state.
    #12;
    check_quiet("reset", 3'd0, 1'b0);
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
    check_eq("reset_ovr", 32'(ovr), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Valids in IDLE: 3 weight-valid edges then 2 vector-valid edges.
    w_valid = 1'b1;
    tick_n(3);
    w_valid = 1'b0;
    raw_valid = 1'b1;
    tick_n(2);
    raw_valid = 1'b0;
    settle();
    check_quiet("idle", 3'd0, 1'b0);
    check_eq("idle_no_wr", 32'(total_wr()), 32'd0);
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
    check_eq("idle_ovr", 32'(ovr), 32'd5);
`endif

    // Start: rise before the edge -> WVAL with request high at that edge.
    start_init = 1'b1;
    w_valid = 1'b1;
    settle();
    check_eq("pre_start_req", 32'(ld_w_req), 32'd0);
    tick();
    check_eq("start_phase", 32'(phase), 32'd1);
    check_eq("start_req", 32'(ld_w_req), 32'd1);
    check_eq("wv0_cen", 32'(wv_cen), 32'b110);
    check_eq("wv0_wen", 32'(w_wen), 32'd0);
    check_eq("wv0_addr", 32'(w_addr), 32'd0);
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
    check_eq("start_ovr_clr", 32'(ovr), 32'd0);
`endif

    // start_init drop after the accept at cnt 100.
    tick_n(100);
    check_eq("wv100_addr", 32'(w_addr), 32'd100);
    start_init = 1'b0;
    tick();
    check_eq("drop_req", 32'(ld_w_req), 32'd0);
    check_eq("drop_cen", 32'(wv_cen), 32'b111);
    snap = total_wr();
    tick_n(10);
    start_init = 1'b1;
    settle();
    check_eq("drop_req_low", 32'(ld_w_req), 32'd0);
    tick();
    check_eq("drop_no_wr", 32'(total_wr() - snap), 32'd0);
    check_eq("resume_req", 32'(ld_w_req), 32'd1);
    check_eq("resume_addr", 32'(w_addr), 32'd101);
    check_eq("resume_cen", 32'(wv_cen), 32'b110);

    // Bank boundary 0 -> 1.
    tick_n(3994);
    check_eq("b0_last_cen", 32'(wv_cen), 32'b110);
    check_eq("b0_last_addr", 32'(w_addr), 32'hFFF);
    tick();
    check_eq("b1_first_cen", 32'(wv_cen), 32'b101);
    check_eq("b1_first_addr", 32'(w_addr), 32'h000);

    // Last WVAL item, then WPOS with no request gap.
    tick_n(8191);
    check_eq("wv_last_cen", 32'(wv_cen), 32'b011);
    check_eq("wv_last_addr", 32'(w_addr), 32'hFFF);
    check_eq("wv_last_phase", 32'(phase), 32'd1);
    tick();
    check_eq("wpos_phase", 32'(phase), 32'd2);
    check_eq("wpos_req", 32'(ld_w_req), 32'd1);
    check_eq("wp0_cen", 32'(wp_cen), 32'b110);
    check_eq("wp0_wv_idle", 32'(wv_cen), 32'b111);
    check_eq("wp0_addr", 32'(w_addr), 32'd0);

    tick_n(12287);
    check_eq("wp_last_cen", 32'(wp_cen), 32'b011);
    tick();
    check_eq("bias_phase", 32'(phase), 32'd3);
    check_eq("bias0_pins", {29'd0, ld_w_req, bias_cen, bias_wen}, {29'd0, 3'b100});

    tick_n(255);
    check_eq("bias_last_addr", 32'(bias_addr), 32'd255);
    tick();
    w_valid = 1'b0;
    raw_valid = 1'b1;
    settle();
    check_eq("vec_phase", 32'(phase), 32'd4);
    check_eq("vec_reqs", {30'd0, ld_w_req, raw_req}, {30'd0, 2'b01});
    check_eq("vec0_pins", {19'd0, vec_cen, vec_addr}, {19'd0, 1'b0, 12'd0});

    tick_n(4095);
    check_eq("vec_last_addr", 32'(vec_addr), 32'hFFF);
    check_eq("vec_last_done", 32'(load_done), 32'd0);
    tick();
    // raw_valid still high here, the cycle after the last vector accept.
    check_eq("done_phase", 32'(phase), 32'd5);
    check_eq("done_flag", 32'(load_done), 32'd1);
    check_eq("done_raw_req", 32'(raw_req), 32'd0);
    check_eq("done_vec_cen", 32'(vec_cen), 32'd1);
    tick();
    raw_valid = 1'b0;
    w_valid = 1'b1;
    settle();
    check_quiet("done", 3'd5, 1'b1);
    tick();
    w_valid = 1'b0;
    settle();

    check_eq("n_wv_b0", 32'(n_wv[0]), 32'd4096);
    check_eq("n_wv_b1", 32'(n_wv[1]), 32'd4096);
    check_eq("n_wv_b2", 32'(n_wv[2]), 32'd4096);
    check_eq("n_wp", 32'(n_wp), 32'd12288);
    check_eq("n_bias", 32'(n_bias), 32'd256);
    check_eq("n_vec", 32'(n_vec), 32'd4096);
    check_eq("mon_err_run1", 32'(mon_err), 32'd0);
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
    // 11 drop cycles + cycle after last vector + one DONE pulse.
    check_eq("run1_ovr", 32'(ovr), 32'd13);
`endif

    // Second load from DONE, reset at BIAS cnt 50.
    start_init = 1'b0;
    tick();
    start_init = 1'b1;
    w_valid = 1'b1;
    tick();
    check_eq("run2_phase", 32'(phase), 32'd1);
    check_eq("run2_addr", 32'(w_addr), 32'd0);
    check_eq("run2_cen", 32'(wv_cen), 32'b110);
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
    check_eq("run2_ovr_clr", 32'(ovr), 32'd0);
`endif
    tick_n(12288);
    check_eq("run2_wpos", 32'(phase), 32'd2);
    tick_n(12288);
    check_eq("run2_bias", 32'(phase), 32'd3);
    tick_n(50);
    check_eq("run2_bias50", {23'd0, bias_cen, bias_addr}, {23'd0, 1'b0, 8'd50});

    rst = 1'b1;
    start_init = 1'b0;
    w_valid = 1'b0;
    settle();
    check_quiet("midrst", 3'd0, 1'b0);
`ifdef SPMDV_LDSEQ_OVERRUN_CNT_EN
    check_eq("midrst_ovr", 32'(ovr), 32'd0);
`endif
    tick_n(2);
    rst = 1'b0;
    tick();
    check_quiet("post_rst", 3'd0, 1'b0);
    start_init = 1'b1;
    w_valid = 1'b1;
    settle();
    check_eq("restart_pre", 32'(wv_cen), 32'b111);
    tick();
    check_eq("restart_phase", 32'(phase), 32'd1);
    check_eq("restart_req", 32'(ld_w_req), 32'd1);
    check_eq("restart_cen", 32'(wv_cen), 32'b110);
    check_eq("restart_addr", 32'(w_addr), 32'd0);
    tick();
    check_eq("restart_addr1", 32'(w_addr), 32'd1);
    check_eq("mon_err_all", 32'(mon_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spmdv_load_sequencer.md
# spmdv_load_sequencer

Controller that runs the SpMDV initialisation load: sparse weight values, weight positions, bias and the 16 input vectors. It drives the `ld_w_request`/`raw_data_request` handshakes toward the external source and the chip-enable, write-enable and address pins of the weight-value, weight-position, bias and vector SRAMs. It replaces ad-hoc load sequencing in the compute top. Once `load_done` is asserted, it hands SRAM ownership to the compute engine.

## Interface
- BANK_DEPTH, 4096, words per weight bank; also the vector SRAM depth
- NUM_BANKS, 3, weight banks per array; 3×4096 = 12288 entries
- BIAS_DEPTH, 256, bias entries
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start_init  in  1  level; enables weight and bias requests
- w_input_valid  in  1  weight/bias byte valid
- raw_data_valid  in  1  vector byte valid
- ld_w_request  out  1  weight/bias request (registered)
- raw_data_request  out  1  vector request (registered)
- wv_cen  out  3  weight-value bank CEN, active-low, one-hot-low
- wp_cen  out  3  weight-position bank CEN, active-low
- w_wen  out  1  weight bank WEN, active-low
- w_addr  out  12  weight bank address
- bias_cen, bias_wen  out  1 each  bias SRAM CEN/WEN, active-low
- bias_addr  out  8
- vec_cen, vec_wen  out  1 each  vector SRAM CEN/WEN, active-low
- vec_addr  out  12
- phase  out  3  current state encoding
- load_done  out  1  high in DONE

## Operation
- States: IDLE(0), WVAL(1), WPOS(2), BIAS(3), VEC(4), DONE(5).
- Accept rule: an item is accepted in a cycle only when the phase's valid is 1 and its request is 1. Valids while the request is 0 are ignored; no write occurs.
- On accept, the enables and address are driven combinationally so the SRAM writes on that edge:
  - WVAL/WPOS: `cnt` (14 b) splits into bank = `cnt[13:12]` and `w_addr` = `cnt[11:0]`. The selected `wv_cen` (WVAL) or `wp_cen` (WPOS) bit goes 0 and `w_wen` goes 0.
  - BIAS: `bias_addr` = `cnt[7:0]`.
  - VEC: `vec_addr` = `cnt[11:0]`.
  - `cnt` increments by 1.
- With no accept, every CEN and WEN is 1 and all addresses are 0.
- Transitions, where "last" means the accept of the final item:
  - IDLE→WVAL: `start_init` rising edge (0 in the previous cycle, 1 now).
  - WVAL→WPOS: last accept at `cnt` = 12287; `cnt` clears to 0.
  - WPOS→BIAS: last accept at `cnt` = 12287; `cnt` clears.
  - BIAS→VEC: last accept at `cnt` = 255; `cnt` clears.
  - VEC→DONE: last accept at `cnt` = 4095.
  - DONE→WVAL: new `start_init` rising edge; `cnt` clears.
- `ld_w_request` next value = (next state ∈ {WVAL, WPOS, BIAS}) AND `start_init`. It stays high continuously across the WVAL→WPOS→BIAS boundaries, with no gap.
- `raw_data_request` next value = (next state == VEC). It does not depend on `start_init`.
- `start_init` falling mid-weight/bias phase: the request drops on the next edge; `cnt` and state hold; the request resumes when `start_init` returns to 1.

## Timing
- Reset values: requests 0; all CEN/WEN 1; addresses 0; `phase` 0; `load_done` 0; `cnt` 0; edge-detect register 0.
- Startup: `start_init` rises before edge k → state = WVAL and `ld_w_request` = 1 at edge k.
- The write occurs on the same edge as the accept; there is zero-cycle latency from valid to SRAM write.
- The request falls on the edge that registers the last accept of the final item of its source. Therefore at most 12288+12288+256 weight/bias items and 4096 vector items are written.
- `rst` mid-operation: all registers return to reset values immediately. Partially written SRAM contents are left as-is. A new `start_init` edge is required to restart.
- Valid asserted in the cycle the request falls: not accepted.

## Configuration
- SPMDV_LDSEQ_OVERRUN_CNT_EN defined: adds an output `overrun_cnt` (16 b). It increments on each cycle where `w_input_valid` or `raw_data_valid` is 1 while the corresponding request is 0, and saturates at 0xFFFF. It clears on `rst` and on entry to WVAL.
- Macro undefined: no `overrun_cnt` port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `spmdv_pkg` holds:
  - phase enum `spmdv_phase_t` with the codes above;
  - `SPMDV_BANK_DEPTH`, `SPMDV_NUM_BANKS`, `SPMDV_BIAS_DEPTH`, `SPMDV_W_TOTAL` = 12288.
- One sub-module, `spmdv_bank_decode`: combinational. Inputs are bank index (2 b) and an enable; output is a 3-bit active-low CEN vector. It is instantiated for the `wv_cen` and `wp_cen` vectors.

## Test plan
- Full load, continuous valid:
  - exactly 12288 WVAL writes, with bank 0 at `cnt` 0–4095, bank 1 at 4096–8191, bank 2 at 8192–12287;
  - 12288 WPOS writes, 256 BIAS writes, 4096 VEC writes;
  - `load_done` = 1 one edge after the vector at `cnt` = 4095.
- Bank boundary: at `cnt` = 4095, `wv_cen` = 3'b110 with `w_addr` = 0xFFF. The next accept gives `wv_cen` = 3'b101 with `w_addr` = 0x000.
- `start_init` drops at WVAL `cnt` = 100 for 10 cycles with valid held at 1:
  - `ld_w_request` = 0 one edge later;
  - no writes occur;
  - the load resumes at `cnt` = 101.
- Valid pulses during IDLE, DONE, and in the cycle after the last VEC accept → no CEN low. With SPMDV_LDSEQ_OVERRUN_CNT_EN defined, `overrun_cnt` equals the number of such pulses.
- `rst` pulse at BIAS `cnt` = 50 → all outputs return to reset values. A new `start_init` edge restarts at WVAL with `cnt` = 0.
